sram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port pixel SRAM among NUM_REQ requesters, for example the gaussian writer, the FAST buffer loader and the host loader.
- Accepts per-requester read/write commands on a req/gnt handshake.
- Issues one registered SRAM command per cycle.
- Routes read data back to the winning requester with a one-hot valid.
- Supports burst locking so one requester can sweep a buffer row without interleaving.

---
 rtl/sram_port_arbiter_pkg.sv | 19 +
 rtl/sram_port_arbiter_rr_pick.sv | 26 ++
 rtl/sram_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and address-width helpers for the pixel SRAM port arbiter.
// Build option: define ARB_STARVE_EN to enable forced grants for starved requesters.
package fast_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int unsigned addr_w(input int unsigned bound);
    return $clog2(bound) + 1;
  endfunction

  localparam int unsigned DEF_X_MAX = 5;
  localparam int unsigned DEF_Y_MAX = 5;
  localparam int unsigned DEF_AW    = addr_w(DEF_X_MAX);
  localparam int unsigned DEF_YW    = addr_w(DEF_Y_MAX);

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Rotating-priority finder: first set request after ptr (mod N), one-hot result.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  always_comb begin
    int unsigned idx;
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port pixel SRAM among NUM_REQ requesters.
// Build option: ARB_STARVE_EN adds per-requester wait counters and forced grants.
module sram_port_arbiter
  import fast_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 3,
  parameter  int unsigned X_MAX        = 5,
  parameter  int unsigned Y_MAX        = 5,
  parameter  int unsigned STARVE_LIMIT = 8,
  localparam int unsigned AW           = addr_w(X_MAX),
  localparam int unsigned YW           = addr_w(Y_MAX)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ-1:0]    lock,
  input  logic [NUM_REQ*AW-1:0] x_addr_in,
  input  logic [NUM_REQ*YW-1:0] y_addr_in,
  input  logic [NUM_REQ*8-1:0]  wdata_in,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [AW-1:0]         sram_x,
  output logic [YW-1:0]         sram_y,
  output logic [7:0]            sram_wdata,
  input  logic [7:0]            sram_rdata,
  output logic [7:0]            rdata,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [NUM_REQ-1:0]    starve
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      rr_idx;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] rr_req;
  logic [NUM_REQ-1:0] rr_oh;
  logic [NUM_REQ-1:0] force_oh;
  logic               rr_any;
  logic               force_any;
  logic               hold_lock;
  logic               win_we;
  logic [AW-1:0]      win_x;
  logic [YW-1:0]      win_y;
  logic [7:0]         win_wdata;
  logic [NUM_REQ-1:0] rid_q1;
  logic [NUM_REQ-1:0] rid_q2;

  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) owner_oh[i] = (owner == PW'(i));
  end

  // A held lock narrows the rotation to the owner; a dropped lock falls back to full round-robin.
  assign hold_lock = (state == LOCKED) && |(lock & owner_oh);
  assign rr_req    = hold_lock ? (req & owner_oh) : req;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req  (rr_req),
    .ptr  (ptr),
    .pick (rr_oh),
    .any  (rr_any)
  );

  always_comb begin
    gnt = '0;
    if (!clear) gnt = force_any ? force_oh : rr_oh;
  end

  always_comb begin
    rr_idx    = '0;
    win_we    = 1'b0;
    win_x     = '0;
    win_y     = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rr_oh[i]) rr_idx = PW'(i);
      if (gnt[i]) begin
        win_we    = we[i];
        win_x     = x_addr_in[i*AW +: AW];
        win_y     = y_addr_in[i*YW +: YW];
        win_wdata = wdata_in[i*8 +: 8];
      end
    end
  end

  // Forced grants leave state, owner and ptr untouched so the interrupted burst resumes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      ptr   <= PW'(NUM_REQ - 1);
      owner <= '0;
    end else if (clear) begin
      state <= ARB;
      ptr   <= PW'(NUM_REQ - 1);
    end else if (!force_any) begin
      if (rr_any) begin
        ptr <= rr_idx;
        if (lock[rr_idx]) begin
          state <= LOCKED;
          owner <= rr_idx;
        end else begin
          state <= ARB;
        end
      end else if (!hold_lock) begin
        state <= ARB;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_x     <= '0;
      sram_y     <= '0;
      sram_wdata <= '0;
      rid_q1     <= '0;
      rid_q2     <= '0;
    end else begin
      sram_en <= |gnt;
      if (|gnt) begin
        sram_we    <= win_we;
        sram_x     <= win_x;
        sram_y     <= win_y;
        sram_wdata <= win_wdata;
      end
      rid_q1 <= gnt & ~we;
      rid_q2 <= rid_q1;
    end
  end

  assign rdata  = sram_rdata;
  assign rvalid = rid_q2;

`ifdef ARB_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] wait_cnt [NUM_REQ];

  always_comb begin
    force_oh  = '0;
    force_any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!force_any && req[i] && (wait_cnt[i] == CW'(STARVE_LIMIT))) begin
        force_oh[i] = 1'b1;
        force_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
      starve <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
      starve <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i])
          wait_cnt[i] <= '0;
        else if (req[i] && (wait_cnt[i] != CW'(STARVE_LIMIT)))
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
      starve <= starve | force_oh;
    end
  end
`else
  logic unused_limit;

  assign force_oh     = '0;
  assign force_any    = 1'b0;
  assign starve       = '0;
  assign unused_limit = ^STARVE_LIMIT;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized bench for sram_port_arbiter against a rule-level reference model.
module tb_sram_port_arbiter;

  localparam int NUM_REQ      = 3;
  localparam int X_MAX        = 5;
  localparam int Y_MAX        = 5;
  localparam int STARVE_LIMIT = 8;
  localparam int AW           = $clog2(X_MAX) + 1;
  localparam int YW           = $clog2(Y_MAX) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic [NUM_REQ-1:0]    req, we, lock;
  logic [NUM_REQ*AW-1:0] x_addr_in;
  logic [NUM_REQ*YW-1:0] y_addr_in;
  logic [NUM_REQ*8-1:0]  wdata_in;
  logic [NUM_REQ-1:0]    gnt;
  logic                  sram_en, sram_we;
  logic [AW-1:0]         sram_x;
  logic [YW-1:0]         sram_y;
  logic [7:0]            sram_wdata;
  logic [7:0]            sram_rdata = '0;
  logic [7:0]            rdata;
  logic [NUM_REQ-1:0]    rvalid, starve;

  sram_port_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .X_MAX        (X_MAX),
    .Y_MAX        (Y_MAX),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .req        (req),
    .we         (we),
    .lock       (lock),
    .x_addr_in  (x_addr_in),
    .y_addr_in  (y_addr_in),
    .wdata_in   (wdata_in),
    .gnt        (gnt),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_x     (sram_x),
    .sram_y     (sram_y),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .starve     (starve)
  );

  always #5 clk = ~clk;

  // SRAM environment: acts on the DUT's registered command, read data one cycle later.
  logic [7:0] mem [16][16] = '{default: '0};
  always @(posedge clk) begin
    if (sram_en && sram_we) mem[sram_x][sram_y] <= sram_wdata;
    if (sram_en && !sram_we) sram_rdata <= mem[sram_x][sram_y];
    else sram_rdata <= 8'($urandom);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0]         ref_mem [16][16] = '{default: '0};
  logic [AW-1:0]      cur_x  [NUM_REQ];
  logic [YW-1:0]      cur_y  [NUM_REQ];
  logic [7:0]         cur_wd [NUM_REQ];
  int                 m_ptr, m_owner, m_w;
  bit                 m_locked, m_forced;
  int                 m_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] m_starve;
  logic               e_en, e_we;
  logic [AW-1:0]      e_x;
  logic [YW-1:0]      e_y;
  logic [7:0]         e_wd;
  int                 rd_id1, rd_id2;
  logic [7:0]         rd_v1, rd_v2;
  logic [NUM_REQ-1:0] s_gnt, s_rv, s_starve;
  logic               s_en;
  logic [AW-1:0]      s_x;
  logic [YW-1:0]      s_y;
  logic [7:0]         s_rd;

  function automatic void new_addr(input int i);
    cur_x[i]  = AW'($urandom);
    cur_y[i]  = YW'($urandom);
    cur_wd[i] = 8'($urandom);
  endfunction

  function automatic void model_reset();
    m_ptr = NUM_REQ - 1; m_owner = 0; m_locked = 0; m_starve = '0;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    e_en = 0; e_we = 0; e_x = '0; e_y = '0; e_wd = '0;
    rd_id1 = -1; rd_id2 = -1; rd_v1 = '0; rd_v2 = '0;
  endfunction

  function automatic void model_pick(output int w, output bit forced);
    w = -1;
    forced = 0;
    if (clear) return;
`ifdef ARB_STARVE_EN
    for (int i = 0; i < NUM_REQ; i++)
      if (w < 0 && req[i] && m_cnt[i] == STARVE_LIMIT) begin w = i; forced = 1; end
    if (forced) return;
`endif
    if (m_locked && lock[m_owner]) begin
      if (req[m_owner]) w = m_owner;
      return;
    end
    for (int k = 1; k <= NUM_REQ; k++)
      if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
  endfunction

  function automatic void model_update(input int w, input bit forced);
    rd_id2 = rd_id1; rd_v2 = rd_v1; rd_id1 = -1;
    e_en = (w >= 0);
    if (w >= 0) begin
      e_we = we[w]; e_x = cur_x[w]; e_y = cur_y[w]; e_wd = cur_wd[w];
      if (we[w]) ref_mem[cur_x[w]][cur_y[w]] = cur_wd[w];
      else begin rd_id1 = w; rd_v1 = ref_mem[cur_x[w]][cur_y[w]]; end
    end
    if (clear) begin
      m_ptr = NUM_REQ - 1; m_locked = 0; m_starve = '0;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w == i) m_cnt[i] = 0;
        else if (req[i] && m_cnt[i] < STARVE_LIMIT) m_cnt[i]++;
      if (forced) m_starve[w] = 1'b1;
      else if (w >= 0) begin m_ptr = w; m_locked = lock[w]; m_owner = w; end
      else if (!(m_locked && lock[m_owner])) m_locked = 0;
    end
    if (w >= 0) new_addr(w);
  endfunction

  task automatic cycle(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] w,
                       input logic [NUM_REQ-1:0] l, input logic c);
    logic [NUM_REQ-1:0] e_gnt, e_rv;
    @(negedge clk);
    req = r; we = w; lock = l; clear = c;
    for (int i = 0; i < NUM_REQ; i++) begin
      x_addr_in[i*AW +: AW] = cur_x[i];
      y_addr_in[i*YW +: YW] = cur_y[i];
      wdata_in[i*8 +: 8]    = cur_wd[i];
    end
    #1;
    model_pick(m_w, m_forced);
    e_gnt = '0;
    if (m_w >= 0) e_gnt[m_w] = 1'b1;
    e_rv = '0;
    if (rd_id2 >= 0) e_rv[rd_id2] = 1'b1;
    s_gnt = gnt; s_en = sram_en; s_x = sram_x; s_y = sram_y;
    s_rv = rvalid; s_rd = rdata; s_starve = starve;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("sram_en", 32'(sram_en), 32'(e_en));
    chk("sram_we", 32'(sram_we), 32'(e_we));
    chk("sram_x", 32'(sram_x), 32'(e_x));
    chk("sram_y", 32'(sram_y), 32'(e_y));
    chk("sram_wdata", 32'(sram_wdata), 32'(e_wd));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    if (e_rv != '0) chk("rdata", 32'(rdata), 32'(rd_v2));
`ifdef ARB_STARVE_EN
    chk("starve", 32'(starve), 32'(m_starve));
`else
    chk("starve", 32'(starve), 32'(0));
`endif
    @(posedge clk);
    model_update(m_w, m_forced);
  endtask

  initial begin
    logic [NUM_REQ-1:0] rq, rw, rl, rr_exp, g_exp, sv_exp;
    rst = 1'b1; clear = 1'b0; req = '0; we = '0; lock = '0;
    x_addr_in = '0; y_addr_in = '0; wdata_in = '0;
    for (int i = 0; i < NUM_REQ; i++) new_addr(i);
    model_reset();
    #12;
    chk("rst_en", 32'(sram_en), 32'(0));
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_starve", 32'(starve), 32'(0));
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      cycle('0, '0, '0, 1'b0);
      chk("idle_en", 32'(s_en), 32'(0));
    end

    // Round robin, all reading
    for (int k = 0; k < 6; k++) begin
      cycle('1, '0, '0, 1'b0);
      rr_exp = '0;
      rr_exp[k % NUM_REQ] = 1'b1;
      chk("rr_seq", 32'(s_gnt), 32'(rr_exp));
      if (k > 0) chk("rr_en", 32'(s_en), 32'(1));
    end

    // Read return: write 0x5A at (2,3) then read it back through requester 1
    cur_x[1] = 4'd2; cur_y[1] = 4'd3; cur_wd[1] = 8'h5A;
    cycle(3'b010, 3'b010, '0, 1'b0);
    cycle('0, '0, '0, 1'b0);
    cur_x[1] = 4'd2; cur_y[1] = 4'd3;
    cycle(3'b010, 3'b000, '0, 1'b0);
    chk("rd_gnt", 32'(s_gnt), 32'(3'b010));
    cycle('0, '0, '0, 1'b0);
    chk("rd_x", 32'(s_x), 32'(2));
    chk("rd_y", 32'(s_y), 32'(3));
    chk("rd_early", 32'(s_rv), 32'(0));
    cycle('0, '0, '0, 1'b0);
    chk("rd_valid", 32'(s_rv), 32'(3'b010));
    chk("rd_data", 32'(s_rd), 32'(8'h5A));
    cycle('0, '0, '0, 1'b0);
    chk("rd_once", 32'(s_rv), 32'(0));

    // Lock: requester 0 bursts with requester 1 waiting
    cycle('0, '0, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(3'b011, '0, (k < 4) ? 3'b001 : 3'b000, 1'b0);
      chk("lock_seq", 32'(s_gnt), 32'((k < 4) ? 3'b001 : 3'b010));
    end

    // clear while a read is in flight
    cycle(3'b100, '0, '0, 1'b0);
    chk("clr_rd_gnt", 32'(s_gnt), 32'(3'b100));
    cycle('1, '0, '0, 1'b1);
    chk("clr_gnt", 32'(s_gnt), 32'(0));
    cycle('1, '0, '0, 1'b0);
    chk("clr_next", 32'(s_gnt), 32'(3'b001));
    chk("clr_rvalid", 32'(s_rv), 32'(3'b100));

    // Requester 0 locked indefinitely, requester 2 waiting
    cycle('0, '0, '0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cycle(3'b101, '0, 3'b001, 1'b0);
`ifdef ARB_STARVE_EN
      g_exp  = (k == 9) ? 3'b100 : 3'b001;
      sv_exp = (k >= 10) ? 3'b100 : 3'b000;
`else
      g_exp  = 3'b001;
      sv_exp = 3'b000;
`endif
      chk("starve_gnt", 32'(s_gnt), 32'(g_exp));
      chk("starve_flag", 32'(s_starve), 32'(sv_exp));
    end

    // Random traffic honouring the hold-until-granted rule
    rq = '0; rw = '0; rl = '0; s_gnt = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!rq[i] || s_gnt[i]) begin
          rq[i] = ($urandom_range(0, 99) < 60);
          rw[i] = 1'($urandom);
          rl[i] = ($urandom_range(0, 3) == 0);
        end
      cycle(rq, rw, rl, $urandom_range(0, 29) == 0);
    end

    // Async reset in the middle of a burst
    cycle('1, '0, '0, 1'b0);
    cycle('1, '0, '0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_en", 32'(sram_en), 32'(0));
    chk("mrst_we", 32'(sram_we), 32'(0));
    chk("mrst_x", 32'(sram_x), 32'(0));
    chk("mrst_y", 32'(sram_y), 32'(0));
    chk("mrst_wdata", 32'(sram_wdata), 32'(0));
    chk("mrst_rvalid", 32'(rvalid), 32'(0));
    chk("mrst_starve", 32'(starve), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle('0, '0, '0, 1'b0);
      chk("post_rst_idle", 32'(s_en), 32'(0));
    end
    cycle('1, '0, '0, 1'b0);
    chk("post_rst_first", 32'(s_gnt), 32'(3'b001));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
